// File: rtl/impl_gate_sweeper.sv
// Sweeps all four {a,b} vectors through an external implication gate (c = ~a | b) and checks each result.
// Latency: busy for 4*PASSES*(SETTLE_CYCLES+2) cycles after an accepted start; done/pass rise as busy falls.
// Backpressure: none; start is ignored while busy, abort returns to IDLE on the next cycle.
module impl_gate_sweeper #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    output logic             o_gate_a,
    output logic             o_gate_b,
    input  logic             i_gate_c,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic             o_fail_valid,
    output logic [1:0]       o_fail_vec
);

    // Settle counter holds SETTLE_CYCLES-1 down to 0; pass index holds 0..PASSES-1.
    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [PASS_W-1:0] LAST_PASS   = PASS_W'(PASSES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX     = '1;
    localparam logic              NO_SETTLE   = (SETTLE_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK
    } state_t;

    state_t            state;
    logic [1:0]        vec_idx;
    logic [PASS_W-1:0] pass_idx;
    logic [CNT_W-1:0]  settle_cnt;

    logic             expected_c;
    logic             mismatch;
    logic [ERR_W-1:0] err_next;
    logic [1:0]       vec_next;
    logic             last_vec;
    logic             last_pass;

    // Check-cycle decode: expected gate response, saturating error increment, sweep position.
    always_comb begin
        expected_c = ~o_gate_a | o_gate_b;
        mismatch   = (i_gate_c != expected_c);
        err_next   = o_err_cnt;
        if (mismatch && (o_err_cnt != ERR_MAX)) begin
            err_next = o_err_cnt + ERR_W'(1);
        end
        vec_next  = vec_idx + 2'd1;
        last_vec  = (vec_idx == 2'd3);
        last_pass = (pass_idx == LAST_PASS);
    end

    // Sweep sequencer. The vector is registered onto the gate inputs on entry to APPLY,
    // so it is stable for the whole APPLY/SETTLE/CHECK window of that vector.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            vec_idx      <= 2'd0;
            pass_idx     <= '0;
            settle_cnt   <= '0;
            o_gate_a     <= 1'b0;
            o_gate_b     <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_pass       <= 1'b0;
            o_err_cnt    <= '0;
            o_fail_valid <= 1'b0;
            o_fail_vec   <= 2'b00;
        end else if (state == S_IDLE) begin
            // Abort alongside start suppresses the start; results are left untouched.
            if (i_start && !i_abort) begin
                o_done       <= 1'b0;
                o_pass       <= 1'b0;
                o_err_cnt    <= '0;
                o_fail_valid <= 1'b0;
                o_fail_vec   <= 2'b00;
                vec_idx      <= 2'd0;
                pass_idx     <= '0;
                o_gate_a     <= 1'b0;
                o_gate_b     <= 1'b0;
                o_busy       <= 1'b1;
                state        <= S_APPLY;
            end
        end else if (i_abort) begin
            // Abort preempts everything, including a completing CHECK; partial error info is kept.
            state    <= S_IDLE;
            o_busy   <= 1'b0;
            o_gate_a <= 1'b0;
            o_gate_b <= 1'b0;
            o_done   <= 1'b0;
            o_pass   <= 1'b0;
        end else begin
            case (state)
                S_APPLY: begin
                    settle_cnt <= SETTLE_LOAD;
                    state      <= NO_SETTLE ? S_CHECK : S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    o_err_cnt <= err_next;
                    if (mismatch && !o_fail_valid) begin
                        o_fail_valid <= 1'b1;
                        o_fail_vec   <= {o_gate_a, o_gate_b};
                    end
                    if (!last_vec) begin
                        vec_idx               <= vec_next;
                        {o_gate_a, o_gate_b}  <= vec_next;
                        state                 <= S_APPLY;
                    end else if (!last_pass) begin
                        vec_idx               <= 2'd0;
                        pass_idx              <= pass_idx + PASS_W'(1);
                        {o_gate_a, o_gate_b}  <= 2'b00;
                        state                 <= S_APPLY;
                    end else begin
                        state    <= S_IDLE;
                        o_busy   <= 1'b0;
                        o_gate_a <= 1'b0;
                        o_gate_b <= 1'b0;
                        o_done   <= 1'b1;
                        o_pass   <= (err_next == '0);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_impl_gate_sweeper.sv
// Bench for impl_gate_sweeper: three instances with different settle/pass settings share one clock and reset.
// Each sweep pushes its expected vector stream and final result into queues, which are popped as the DUT runs.
// Gate faults (stuck-at-1, stuck-at-0) are modelled in the bench; aborts, ignored starts and mid-sweep reset are covered.
module tb_impl_gate_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start [3];
    logic       abort [3];
    logic [1:0] mode  [3];   // 0: correct gate, 1: stuck-at-1, 2: stuck-at-0

    logic       ga [3];
    logic       gb [3];
    logic       gc [3];
    logic       busy [3];
    logic       done [3];
    logic       pass [3];
    logic       fv [3];
    logic [2:0] errc [3];
    logic [1:0] fvec [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int len;
        int err;
        int pass;
        int done;
        int fv;
        int fvec;
    } res_t;

    res_t       res_q [$];
    logic [1:0] vec_q [$];

    function automatic logic gate_model(input logic [1:0] m, input logic a, input logic b);
        if (m == 2'd1) return 1'b1;
        if (m == 2'd2) return 1'b0;
        return ~a | b;
    endfunction

    assign gc[0] = gate_model(mode[0], ga[0], gb[0]);
    assign gc[1] = gate_model(mode[1], ga[1], gb[1]);
    assign gc[2] = gate_model(mode[2], ga[2], gb[2]);

    impl_gate_sweeper #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(3)) u0 (
        .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_abort(abort[0]),
        .o_gate_a(ga[0]), .o_gate_b(gb[0]), .i_gate_c(gc[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]), .o_err_cnt(errc[0]),
        .o_fail_valid(fv[0]), .o_fail_vec(fvec[0])
    );

    impl_gate_sweeper #(.SETTLE_CYCLES(2), .PASSES(3), .ERR_W(3)) u1 (
        .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_abort(abort[1]),
        .o_gate_a(ga[1]), .o_gate_b(gb[1]), .i_gate_c(gc[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]), .o_err_cnt(errc[1]),
        .o_fail_valid(fv[1]), .o_fail_vec(fvec[1])
    );

    impl_gate_sweeper #(.SETTLE_CYCLES(0), .PASSES(1), .ERR_W(3)) u2 (
        .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_abort(abort[2]),
        .o_gate_a(ga[2]), .o_gate_b(gb[2]), .i_gate_c(gc[2]),
        .o_busy(busy[2]), .o_done(done[2]), .o_pass(pass[2]), .o_err_cnt(errc[2]),
        .o_fail_valid(fv[2]), .o_fail_vec(fvec[2])
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int settle_of(input int k);
        return (k == 2) ? 0 : 2;
    endfunction

    function automatic int passes_of(input int k);
        return (k == 1) ? 3 : 1;
    endfunction

    task automatic chk_all_zero(input int k, input string tag);
        chk($sformatf("%s_busy_u%0d", tag, k), int'(busy[k]), 0);
        chk($sformatf("%s_done_u%0d", tag, k), int'(done[k]), 0);
        chk($sformatf("%s_pass_u%0d", tag, k), int'(pass[k]), 0);
        chk($sformatf("%s_err_u%0d", tag, k), int'(errc[k]), 0);
        chk($sformatf("%s_fv_u%0d", tag, k), int'(fv[k]), 0);
        chk($sformatf("%s_fvec_u%0d", tag, k), int'(fvec[k]), 0);
        chk($sformatf("%s_gate_u%0d", tag, k), int'({ga[k], gb[k]}), 0);
    endtask

    // One sweep on instance k with gate fault m; abort_at>0 raises abort during that busy cycle.
    task automatic run_sweep(input int k, input logic [1:0] m, input int abort_at, input string tag);
        int   s;
        int   p;
        int   len;
        int   cyc;
        int   cnt;
        int   chk_cyc;
        int   fvld;
        int   fvec_e;
        res_t r;
        logic a;
        logic b;
        logic [1:0] v;

        s       = settle_of(k);
        p       = passes_of(k);
        len     = 4 * p * (s + 2);
        mode[k] = m;
        cnt     = 0;
        fvld    = 0;
        fvec_e  = 0;
        for (int pi = 0; pi < p; pi++) begin
            for (int vi = 0; vi < 4; vi++) begin
                v = 2'(vi);
                for (int h = 0; h < s + 2; h++) vec_q.push_back(v);
                chk_cyc = (pi * 4 + vi + 1) * (s + 2);
                a = v[1];
                b = v[0];
                if ((abort_at == 0 || chk_cyc < abort_at) && (gate_model(m, a, b) != (~a | b))) begin
                    if (cnt < 7) cnt++;
                    if (fvld == 0) begin
                        fvld   = 1;
                        fvec_e = vi;
                    end
                end
            end
        end
        r.len  = (abort_at > 0) ? abort_at : len;
        r.err  = cnt;
        r.fv   = fvld;
        r.fvec = fvec_e;
        r.done = (abort_at > 0) ? 0 : 1;
        r.pass = (abort_at == 0 && cnt == 0) ? 1 : 0;
        res_q.push_back(r);

        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        cyc = 0;
        while (busy[k] && cyc < len + 4) begin
            cyc++;
            if (vec_q.size() > 0) begin
                v = vec_q.pop_front();
                chk($sformatf("%s_vec_c%0d", tag, cyc), int'({ga[k], gb[k]}), int'(v));
            end
            start[k] = (cyc == 3) ? 1'b1 : 1'b0;   // must be ignored while busy
            if (cyc == abort_at) abort[k] = 1'b1;
            @(negedge clk);
            abort[k] = 1'b0;
        end
        start[k] = 1'b0;
        vec_q.delete();

        r = res_q.pop_front();
        chk({tag, "_busy_len"}, cyc, r.len);
        chk({tag, "_busy_end"}, int'(busy[k]), 0);
        chk({tag, "_done"}, int'(done[k]), r.done);
        chk({tag, "_pass"}, int'(pass[k]), r.pass);
        chk({tag, "_err"}, int'(errc[k]), r.err);
        chk({tag, "_fv"}, int'(fv[k]), r.fv);
        chk({tag, "_fvec"}, int'(fvec[k]), r.fvec);
        chk({tag, "_gate_idle"}, int'({ga[k], gb[k]}), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            abort[k] = 1'b0;
            mode[k]  = 2'd0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_all_zero(k, "reset");
        rst = 1'b0;

        run_sweep(0, 2'd0, 0, "good_s2");
        run_sweep(0, 2'd1, 0, "stuck1");

        // Start and abort together in IDLE: nothing starts and prior results stay.
        @(negedge clk);
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        abort[0] = 1'b0;
        chk("idle_start_abort_busy", int'(busy[0]), 0);
        chk("idle_start_abort_done", int'(done[0]), 1);
        chk("idle_start_abort_err", int'(errc[0]), 1);
        chk("idle_start_abort_fvec", int'(fvec[0]), 2);

        run_sweep(1, 2'd2, 0, "stuck0_p3_sat");
        run_sweep(2, 2'd0, 0, "good_s0");
        run_sweep(0, 2'd2, 6, "abort_vec1");

        // Synchronous reset in the middle of a sweep, then a fresh sweep.
        mode[0] = 2'd2;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", int'(busy[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero(0, "mid_reset");
        run_sweep(0, 2'd0, 0, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
